// File: rtl/arb_bus_xfer.sv
// arb_bus_xfer
//   Takes the grant from an external 2-input arbiter and moves one locked burst
//   of len_x beats from the winning requester to a ready/valid sink.
//
//   Ports
//     clock, reset         rising-edge clock, asynchronous active-high reset
//     gnt_0, gnt_1         arbiter grants, sampled only in IDLE (gnt_0 wins ties)
//     len_0, len_1         burst length in beats, latched with the grant
//     data_0, data_1       current beat data of each requester
//     out_ready            sink accepts the beat on out_data
//     out_valid            beat present on out_data
//     out_data, out_src    beat data and owner of the current burst
//     ack_0, ack_1         beat consumed from that requester this cycle
//     done_0, done_1       one-cycle pulse when that requester's burst ends
//     busy                 FSM is not in IDLE
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a grant; outputs quiet
//   XFER  | streaming beats from the owner, count = beats remaining
//   DONE  | one-cycle done pulse to the owner, grants ignored
module arb_bus_xfer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic [LEN_W-1:0]  len_0,
    input  logic [LEN_W-1:0]  len_1,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              ack_0,
    output logic              ack_1,
    output logic              done_0,
    output logic              done_1,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   count, count_nxt;
    logic               owner, owner_nxt;
    logic               beat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        owner_nxt = owner;
        beat      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_src   = 1'b0;
        ack_0     = 1'b0;
        ack_1     = 1'b0;
        done_0    = 1'b0;
        done_1    = 1'b0;
        busy      = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (gnt_0) begin
                    owner_nxt = 1'b0;
                    count_nxt = len_0;
                    state_nxt = (len_0 != '0) ? ST_XFER : ST_DONE;
                end else if (gnt_1) begin
                    owner_nxt = 1'b1;
                    count_nxt = len_1;
                    state_nxt = (len_1 != '0) ? ST_XFER : ST_DONE;
                end
            end
            ST_XFER: begin
                out_valid = 1'b1;
                out_src   = owner;
                out_data  = owner ? data_1 : data_0;
                beat      = out_ready;
                ack_0     = beat & ~owner;
                ack_1     = beat &  owner;
                if (beat) begin
                    // count is never zero in XFER; the guard only keeps a
                    // corrupted count from wrapping to the maximum length.
                    if (count != '0)
                        count_nxt = count - 1'b1;
                    if (count <= 1)
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_src   = owner;
                done_0    = ~owner;
                done_1    =  owner;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arb_bus_xfer.sv
// tb_arb_bus_xfer
//   Directed bench for arb_bus_xfer. Inputs change 1 ns after a rising edge,
//   outputs are sampled 1 ns after that, so every check sees settled values.
module tb_arb_bus_xfer;

    logic       clock;
    logic       reset;
    logic       gnt_0, gnt_1;
    logic [3:0] len_0, len_1;
    logic [7:0] data_0, data_1;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       ack_0, ack_1, done_0, done_1, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ack    = 0;

    arb_bus_xfer #(.DATA_W(8), .LEN_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .len_0     (len_0),
        .len_1     (len_1),
        .data_0    (data_0),
        .data_1    (data_1),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .ack_0     (ack_0),
        .ack_1     (ack_1),
        .done_0    (done_0),
        .done_1    (done_1),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance past the next rising edge, leaving 1 ns before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {out_valid, ack_0, ack_1, done_0, done_1, busy, out_src};
    endfunction

    initial begin
        reset = 1'b1; gnt_0 = 0; gnt_1 = 0; len_0 = 0; len_1 = 0;
        data_0 = 8'h00; data_1 = 8'h00; out_ready = 0;
        tick(); tick();
        data_0 = 8'h5A; data_1 = 8'hA5;
        settle();
        check("reset_outs", {25'd0, outs()}, 32'd0);
        check("reset_data", out_data, 8'h00);
        reset = 1'b0;

        // Burst of 3 from requester 0, sink always ready.
        gnt_0 = 1; len_0 = 3; data_0 = 8'hA0; out_ready = 1;
        settle();
        check("t1_idle_quiet", {25'd0, outs()}, 32'd0);
        tick();
        gnt_0 = 0; len_0 = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t1_valid", out_valid, 1);
            check("t1_ack0", ack_0, 1);
            check("t1_ack1", ack_1, 0);
            check("t1_data", out_data, 8'hA0 + i);
            check("t1_src", out_src, 0);
            tick();
            data_0 = 8'hA1 + i;
        end
        settle();
        check("t1_done", {out_valid, done_0, done_1, busy}, 4'b0101);
        tick();
        check("t1_idle", {25'd0, outs()}, 32'd0);

        // Burst of 2 from requester 1 with a stalling sink.
        gnt_1 = 1; len_1 = 2; data_1 = 8'hB0; out_ready = 0;
        tick();
        gnt_1 = 0; len_1 = 0;
        settle();
        check("t2_stall_a", {out_valid, ack_1, out_src}, 3'b101);
        check("t2_stall_a_data", out_data, 8'hB0);
        tick();
        out_ready = 1; settle();
        check("t2_beat_a", {out_valid, ack_1, ack_0, out_src}, 4'b1101);
        check("t2_beat_a_data", out_data, 8'hB0);
        tick();
        data_1 = 8'hB1; out_ready = 0; settle();
        check("t2_stall_b", {out_valid, ack_1, out_src}, 3'b101);
        check("t2_stall_b_data", out_data, 8'hB1);
        tick();
        out_ready = 1; settle();
        check("t2_beat_b", {out_valid, ack_1, out_src}, 3'b111);
        check("t2_beat_b_data", out_data, 8'hB1);
        tick();
        check("t2_done", {out_valid, done_0, done_1, busy}, 4'b0011);
        tick();
        check("t2_idle", busy, 0);

        // Zero-length grant goes straight to DONE.
        gnt_0 = 1; len_0 = 0;
        tick();
        gnt_0 = 0; settle();
        check("t3_done", {out_valid, ack_0, done_0, done_1, busy}, 5'b00101);
        tick();
        check("t3_idle", {25'd0, outs()}, 32'd0);

        // Both grants: requester 0 wins.
        gnt_0 = 1; gnt_1 = 1; len_0 = 1; len_1 = 4; data_0 = 8'hC0; data_1 = 8'hD0;
        tick();
        gnt_0 = 0; gnt_1 = 0; settle();
        check("t4_beat", {out_valid, ack_0, ack_1, out_src}, 4'b1100);
        check("t4_data", out_data, 8'hC0);
        tick();
        check("t4_done", {done_0, done_1, ack_1}, 3'b100);
        tick();
        check("t4_idle", busy, 0);

        // 15-beat lock on requester 1 while grants swap mid-burst.
        gnt_1 = 1; len_1 = 15; data_1 = 8'hE0;
        tick();
        n_ack = 0;
        for (int i = 0; i < 15; i++) begin
            if (i == 2) begin
                gnt_1 = 0; gnt_0 = 1; len_0 = 2; len_1 = 1;
            end
            settle();
            if (ack_1) n_ack++;
            check("t5_owner", {out_valid, out_src, ack_0}, 3'b110);
            check("t5_data", out_data, 8'hE0 + i);
            tick();
            data_1 = 8'hE1 + i;
        end
        check("t5_acks", n_ack, 15);
        check("t5_done", {done_0, done_1, out_valid}, 3'b010);
        tick();
        check("t5_gap", busy, 0);
        data_0 = 8'h70;
        tick();
        gnt_0 = 0; settle();
        check("t5_next", {out_valid, out_src, ack_0}, 3'b101);
        check("t5_next_data", out_data, 8'h70);
        tick(); tick();
        check("t5_next_done", done_0, 1);
        tick();

        // Reset during beat 2 of a 4-beat burst.
        gnt_0 = 1; len_0 = 4; data_0 = 8'h40;
        tick();
        gnt_0 = 0; settle();
        check("t6_beat1", ack_0, 1);
        tick();
        data_0 = 8'h41; settle();
        check("t6_beat2", {out_valid, ack_0}, 2'b11);
        reset = 1; settle();
        check("t6_reset_outs", {25'd0, outs()}, 32'd0);
        check("t6_reset_data", out_data, 8'h00);
        tick();
        check("t6_reset_hold", {25'd0, outs()}, 32'd0);
        reset = 0;
        tick();
        check("t6_no_done", {done_0, busy}, 2'b00);
        gnt_0 = 1; len_0 = 1; data_0 = 8'h90;
        tick();
        gnt_0 = 0; settle();
        check("t6_restart", {out_valid, ack_0, out_src}, 3'b110);
        check("t6_restart_data", out_data, 8'h90);
        tick();
        check("t6_restart_done", done_0, 1);
        tick();
        check("t6_restart_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arb_bus_xfer.md
ARB_BUS_XFER -- requirements
Module: arb_bus_xfer

Interface
REQ-001 SHALL have parameter: DATA_W, 8, width of the data path.
REQ-002 SHALL have parameter: LEN_W, 4, width of the burst-length fields.
REQ-003 SHALL have port: clock  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: gnt_0  input  1  grant for requester 0, from the 2-input arbiter.
REQ-006 SHALL have port: gnt_1  input  1  grant for requester 1, from the 2-input arbiter.
REQ-007 SHALL have port: len_0  input  LEN_W  burst length in beats, requester 0.
REQ-008 SHALL have port: len_1  input  LEN_W  burst length in beats, requester 1.
REQ-009 SHALL have port: data_0  input  DATA_W  current beat data, requester 0.
REQ-010 SHALL have port: data_1  input  DATA_W  current beat data, requester 1.
REQ-011 SHALL have port: out_ready  input  1  downstream sink accepts a beat.
REQ-012 SHALL have port: out_valid  output  1  beat present on out_data.
REQ-013 SHALL have port: out_data  output  DATA_W  beat data.
REQ-014 SHALL have port: out_src  output  1  owner of the current burst (0 or 1).
REQ-015 SHALL have port: ack_0 / ack_1  output  1 each  beat consumed from the named requester; requester advances data on the next cycle.
REQ-016 SHALL have port: done_0 / done_1  output  1 each  single-cycle pulse at burst end.
REQ-017 SHALL have port: busy  output  1  high in every state other than IDLE.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, XFER, DONE.
REQ-019 In IDLE, SHALL sample the grant inputs at each rising edge.
- gnt_0=1: owner=0, count=len_0.
- else gnt_1=1: owner=1, count=len_1.
- gnt_0 takes precedence if both grants are high.
REQ-020 On a sampled grant with a nonzero latched length, SHALL go to XFER.
REQ-021 On a sampled grant with a zero latched length, SHALL go directly to DONE with no beats transferred.
REQ-022 In XFER:
- out_valid=1.
- out_data = data_<owner>, combinational from the selected input.
- out_src = owner.
REQ-023 In XFER, a beat SHALL transfer in any cycle with out_valid & out_ready.
- ack_<owner>=1 combinationally in that cycle.
- count decrements by 1 at the next edge.
REQ-024 When a beat transfers with count==1, SHALL go to DONE at the next edge.
REQ-025 In DONE, SHALL hold for exactly one cycle.
- done_<owner>=1, out_valid=0.
- Then IDLE.
REQ-026 out_valid SHALL first assert one cycle after the edge that samples the grant, and SHALL NOT drop until the last beat transfers.
REQ-027 out_data and out_src SHALL be held stable while out_valid=1 and out_ready=0.
REQ-028 A burst SHALL be locked once started: grant changes during XFER/DONE are ignored and len_x changes have no effect.
REQ-029 No grant SHALL be sampled in DONE; the earliest new burst starts from IDLE, giving at least one idle cycle between bursts.
REQ-030 ack_x, done_x and out_valid SHALL be 0 in IDLE.
REQ-031 ack for the non-owner and done for the non-owner SHALL always be 0.
REQ-032 count SHALL never underflow; maximum burst = 2^LEN_W-1 beats.

Reset
REQ-033 reset=1 SHALL asynchronously force state=IDLE, count=0, owner=0.
REQ-034 While reset=1, all outputs SHALL be 0 (out_valid, out_data, out_src, ack_x, done_x, busy).
REQ-035 Reset asserted mid-burst SHALL abort the burst with no done pulse; the FSM resumes in IDLE on the first edge after deassertion.

Verification
REQ-036 Bench SHALL cover: gnt_0=1 for one cycle, len_0=3, out_ready=1 -> out_valid high 3 cycles with ack_0 each cycle, then done_0 pulse, busy low after 5 cycles total.
REQ-037 Bench SHALL cover: gnt_1=1, len_1=2, out_ready toggling 0,1,0,1 -> exactly 2 acks, out_data stable while stalled, out_src=1, then done_1.
REQ-038 Bench SHALL cover: gnt_0=1, len_0=0 -> no out_valid, done_0 pulse on the cycle after the sampling edge.
REQ-039 Bench SHALL cover: gnt_0 and gnt_1 both high, len_0=1, len_1=4 -> single beat from data_0, done_0, no activity on ack_1/done_1.
REQ-040 Bench SHALL cover: burst len_1=15 with gnt_1 dropped and gnt_0 raised after beat 2 -> all 15 beats from requester 1 complete before requester 0 is served.
REQ-041 Bench SHALL cover: reset pulsed during beat 2 of a len_0=4 burst -> all outputs 0 immediately, no done_0, and a subsequent grant restarts normally.
